// File: rtl/ssd_marquee_scan_if.sv
// Bundles the marquee scanner's load/enable inputs and display-side outputs.
// The master drives the codes and strobes; the slave is the scanner itself.
interface ssd_marquee_scan_if;
  logic       en;
  logic       load;
  logic [3:0] in3;
  logic [3:0] in2;
  logic [3:0] in1;
  logic [3:0] in0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       load_pending;
  logic       frame_tick;

  modport master (
    output en, load, in3, in2, in1, in0,
    input  an, seg, load_pending, frame_tick
  );

  modport slave (
    input  en, load, in3, in2, in1, in0,
    output an, seg, load_pending, frame_tick
  );
endinterface

// File: rtl/ssd_marquee_scan.sv
// Four-digit common-anode seven-segment scanner for the marquee character stream.
// Shadowed codes are committed only at frame boundaries so a scan never tears.
module ssd_marquee_scan #(
  parameter int unsigned SCAN_CNT_MAX = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter int unsigned CNT_W        = 17
) (
  input logic               clk,
  input logic               rst_n,
  ssd_marquee_scan_if.slave bus
);

  localparam logic [CNT_W-1:0] CntLast  = CNT_W'(SCAN_CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CntBlank = CNT_W'(BLANK_CYCLES);
  localparam logic [3:0]       CodeBlank = 4'b1000;
  localparam logic [6:0]       SegOff    = 7'b1111111;

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] s;
    s = SegOff;
    unique case (code)
      4'h0:    s = 7'b0000110;  // E
      4'h1:    s = 7'b0001001;  // H
      4'h2:    s = 7'b0101011;  // n
      4'h3:    s = 7'b0000111;  // t
      4'h4:    s = 7'b1000001;  // U
      4'h5:    s = 7'b1000110;  // C
      4'h6:    s = 7'b0010010;  // S
      4'h7:    s = 7'b0111111;  // dash
      default: s = SegOff;
    endcase
    return s;
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0][3:0]  shadow_q, shadow_d;
  logic [3:0][3:0]  active_q, active_d;
  logic             pending_q, pending_d;
  logic             boundary_q, boundary_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             tick_q, tick_d;

  logic [3:0][3:0]  in_codes;
  logic             wrap;
  logic             boundary;

  always_comb begin
    in_codes = {bus.in3, bus.in2, bus.in1, bus.in0};
    wrap     = (cnt_q == CntLast);
    boundary = bus.en && wrap && (idx_q == 2'd0);

    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shadow_d   = shadow_q;
    active_d   = active_q;
    pending_d  = pending_q;
    boundary_d = boundary;
    an_d       = 4'hf;
    seg_d      = SegOff;
    tick_d     = 1'b0;

    if (bus.en) begin
      if (wrap) begin
        cnt_d = '0;
        idx_d = idx_q - 2'd1;  // 0 wraps back to 3
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
      idx_d = 2'd3;
    end

    if (bus.load) begin
      shadow_d  = in_codes;
      pending_d = 1'b1;
    end

    if (boundary) begin
      // A load landing on the boundary goes straight to the display.
      if (bus.load) begin
        active_d  = in_codes;
        pending_d = 1'b0;
      end else if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end else if (!bus.en && pending_q) begin
      // Display is dark, so committing immediately cannot tear.
      active_d  = shadow_q;
      pending_d = bus.load;
    end

    if (bus.en) begin
      an_d   = (cnt_q < CntBlank) ? 4'hf : ~(4'b0001 << idx_q);
      seg_d  = decode(active_q[idx_q]);
      tick_d = boundary_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= 2'd3;
      shadow_q   <= {4{CodeBlank}};
      active_q   <= {4{CodeBlank}};
      pending_q  <= 1'b0;
      boundary_q <= 1'b0;
      an_q       <= 4'hf;
      seg_q      <= SegOff;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      boundary_q <= boundary_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      tick_q     <= tick_d;
    end
  end

  assign bus.an           = an_q;
  assign bus.seg          = seg_q;
  assign bus.load_pending = pending_q;
  assign bus.frame_tick   = tick_q;

endmodule

// File: tb/tb_ssd_marquee_scan.sv
// Directed bench for ssd_marquee_scan with an 8-cycle slot and 2-cycle blank window.
// k counts rising edges since the last reset release; all sampling is on the falling edge.
module tb_ssd_marquee_scan;

  localparam logic [6:0] SegOff  = 7'b1111111;
  localparam logic [6:0] SegN    = 7'b0101011;
  localparam logic [6:0] SegT    = 7'b0000111;
  localparam logic [6:0] SegH    = 7'b0001001;
  localparam logic [6:0] SegU    = 7'b1000001;
  localparam logic [6:0] SegS    = 7'b0010010;
  localparam logic [6:0] SegDash = 7'b0111111;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ssd_marquee_scan_if bus ();

  ssd_marquee_scan #(
    .SCAN_CNT_MAX(8),
    .BLANK_CYCLES(2),
    .CNT_W       (3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  int k     = 0;

  // Anode pattern after edge kk for an uninterrupted scan started from reset.
  function automatic logic [3:0] exp_an(input int kk);
    int m;
    int c;
    int d;
    m = kk - 1;
    c = m % 8;
    d = 3 - ((m / 8) % 4);
    if (c < 2) return 4'hf;
    return ~(4'b0001 << d);
  endfunction

  task automatic cyc();
    @(negedge clk);
    k++;
  endtask

  task automatic run_to(input int t);
    while (k < t) cyc();
  endtask

  task automatic set_codes(input logic [3:0] c3, input logic [3:0] c2,
                           input logic [3:0] c1, input logic [3:0] c0);
    bus.in3 = c3;
    bus.in2 = c2;
    bus.in1 = c1;
    bus.in0 = c0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    bus.en   = 1'b1;
    bus.load = 1'b0;
    set_codes(4'h0, 4'h0, 4'h0, 4'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    k     = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (bus.an !== 4'hf) begin
      bad++;
      $display("FAIL reset_an got=%b want=1111", bus.an);
    end
    total++;
    if (bus.seg !== SegOff) begin
      bad++;
      $display("FAIL reset_seg got=%b want=%b", bus.seg, SegOff);
    end
    total++;
    if (bus.load_pending !== 1'b0) begin
      bad++;
      $display("FAIL reset_pending got=%b want=0", bus.load_pending);
    end
    total++;
    if (bus.frame_tick !== 1'b0) begin
      bad++;
      $display("FAIL reset_tick got=%b want=0", bus.frame_tick);
    end
  endtask

  task automatic test_idle();
    logic want_tick;
    do_reset();
    while (k < 70) begin
      cyc();
      want_tick = (k == 33) || (k == 65);
      total++;
      if (bus.an !== exp_an(k)) begin
        bad++;
        $display("FAIL idle_an k=%0d got=%b want=%b", k, bus.an, exp_an(k));
      end
      total++;
      if (bus.seg !== SegOff) begin
        bad++;
        $display("FAIL idle_seg k=%0d got=%b want=%b", k, bus.seg, SegOff);
      end
      total++;
      if (bus.frame_tick !== want_tick) begin
        bad++;
        $display("FAIL idle_tick k=%0d got=%b want=%b", k, bus.frame_tick, want_tick);
      end
    end
  endtask

  task automatic test_commit();
    do_reset();
    run_to(4);
    bus.load = 1'b1;
    set_codes(4'h2, 4'h3, 4'h1, 4'h4);
    cyc();
    bus.load = 1'b0;
    total++;
    if (bus.load_pending !== 1'b1) begin
      bad++;
      $display("FAIL commit_pending_set got=%b want=1", bus.load_pending);
    end
    run_to(31);
    total++;
    if (bus.load_pending !== 1'b1 || bus.seg !== SegOff) begin
      bad++;
      $display("FAIL commit_pre_boundary pending=%b seg=%b want pending=1 seg=%b",
               bus.load_pending, bus.seg, SegOff);
    end
    cyc();
    total++;
    if (bus.load_pending !== 1'b0 || bus.seg !== SegOff) begin
      bad++;
      $display("FAIL commit_boundary pending=%b seg=%b want pending=0 seg=%b",
               bus.load_pending, bus.seg, SegOff);
    end
    cyc();
    total++;
    if (bus.seg !== SegN || bus.frame_tick !== 1'b1 || bus.an !== 4'hf) begin
      bad++;
      $display("FAIL commit_digit3 seg=%b tick=%b an=%b want seg=%b tick=1 an=1111",
               bus.seg, bus.frame_tick, bus.an, SegN);
    end
    run_to(43);
    total++;
    if (bus.seg !== SegT || bus.an !== 4'b1011) begin
      bad++;
      $display("FAIL commit_digit2 seg=%b an=%b want seg=%b an=1011", bus.seg, bus.an, SegT);
    end
    run_to(49);
    total++;
    if (bus.seg !== SegH) begin
      bad++;
      $display("FAIL commit_digit1 got=%b want=%b", bus.seg, SegH);
    end
    run_to(59);
    total++;
    if (bus.seg !== SegU || bus.an !== 4'b1110) begin
      bad++;
      $display("FAIL commit_digit0 seg=%b an=%b want seg=%b an=1110", bus.seg, bus.an, SegU);
    end
  endtask

  task automatic test_last_wins();
    logic [6:0] want;
    do_reset();
    while (k < 64) begin
      bus.load = (k == 2) || (k == 19);
      if (k == 2) set_codes(4'h0, 4'h0, 4'h5, 4'h6);
      if (k == 19) set_codes(4'h7, 4'h7, 4'h7, 4'h7);
      cyc();
      bus.load = 1'b0;
      want = (k <= 32) ? SegOff : SegDash;
      total++;
      if (bus.seg !== want) begin
        bad++;
        $display("FAIL last_wins_seg k=%0d got=%b want=%b", k, bus.seg, want);
      end
      if (k == 20 || k == 32) begin
        total++;
        if (bus.load_pending !== (k == 20)) begin
          bad++;
          $display("FAIL last_wins_pending k=%0d got=%b want=%b", k, bus.load_pending, k == 20);
        end
      end
    end
  endtask

  task automatic test_boundary_load();
    do_reset();
    set_codes(4'h6, 4'h6, 4'h6, 4'h6);
    while (k < 40) begin
      bus.load = (k == 31);
      cyc();
      bus.load = 1'b0;
      total++;
      if (bus.load_pending !== 1'b0) begin
        bad++;
        $display("FAIL bnd_pending k=%0d got=%b want=0", k, bus.load_pending);
      end
      if (k == 33) begin
        total++;
        if (bus.seg !== SegS || bus.frame_tick !== 1'b1) begin
          bad++;
          $display("FAIL bnd_digit3 seg=%b tick=%b want seg=%b tick=1",
                   bus.seg, bus.frame_tick, SegS);
        end
      end
    end
  endtask

  task automatic test_enable_gap();
    do_reset();
    run_to(20);
    total++;
    if (bus.an !== 4'b1101) begin
      bad++;
      $display("FAIL gap_lit_before got=%b want=1101", bus.an);
    end
    bus.en = 1'b0;
    cyc();
    total++;
    if (bus.an !== 4'hf || bus.seg !== SegOff || bus.frame_tick !== 1'b0) begin
      bad++;
      $display("FAIL gap_dark an=%b seg=%b tick=%b want an=1111 seg=%b tick=0",
               bus.an, bus.seg, bus.frame_tick, SegOff);
    end
    bus.load = 1'b1;
    set_codes(4'h4, 4'h4, 4'h4, 4'h4);
    cyc();
    bus.load = 1'b0;
    total++;
    if (bus.load_pending !== 1'b1) begin
      bad++;
      $display("FAIL gap_pending_set got=%b want=1", bus.load_pending);
    end
    cyc();
    total++;
    if (bus.load_pending !== 1'b0 || bus.an !== 4'hf || bus.seg !== SegOff) begin
      bad++;
      $display("FAIL gap_commit pending=%b an=%b seg=%b want pending=0 an=1111 seg=%b",
               bus.load_pending, bus.an, bus.seg, SegOff);
    end
    run_to(25);
    bus.en = 1'b1;
    cyc();
    total++;
    if (bus.an !== 4'hf || bus.seg !== SegU || bus.frame_tick !== 1'b0) begin
      bad++;
      $display("FAIL gap_restart an=%b seg=%b tick=%b want an=1111 seg=%b tick=0",
               bus.an, bus.seg, bus.frame_tick, SegU);
    end
    cyc();
    total++;
    if (bus.an !== 4'hf) begin
      bad++;
      $display("FAIL gap_blank2 got=%b want=1111", bus.an);
    end
    cyc();
    total++;
    if (bus.an !== 4'b0111 || bus.seg !== SegU || bus.frame_tick !== 1'b0) begin
      bad++;
      $display("FAIL gap_first_lit an=%b seg=%b tick=%b want an=0111 seg=%b tick=0",
               bus.an, bus.seg, bus.frame_tick, SegU);
    end
    run_to(57);
    total++;
    if (bus.frame_tick !== 1'b0) begin
      bad++;
      $display("FAIL gap_tick_early got=%b want=0", bus.frame_tick);
    end
    cyc();
    total++;
    if (bus.frame_tick !== 1'b1) begin
      bad++;
      $display("FAIL gap_tick_frame got=%b want=1", bus.frame_tick);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_to(4);
    bus.load = 1'b1;
    set_codes(4'h0, 4'h0, 4'h0, 4'h0);
    cyc();
    bus.load = 1'b0;
    run_to(13);
    total++;
    if (bus.an !== 4'b1011 || bus.load_pending !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_before an=%b pending=%b want an=1011 pending=1",
               bus.an, bus.load_pending);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.an !== 4'hf || bus.seg !== SegOff || bus.load_pending !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_async an=%b seg=%b pending=%b want an=1111 seg=%b pending=0",
               bus.an, bus.seg, bus.load_pending, SegOff);
    end
    @(negedge clk);
    rst_n = 1'b1;
    k     = 0;
    while (k < 40) begin
      cyc();
      total++;
      if (bus.an !== exp_an(k) || bus.seg !== SegOff || bus.load_pending !== 1'b0) begin
        bad++;
        $display("FAIL rstmid_after k=%0d an=%b seg=%b pending=%b want an=%b seg=%b pending=0",
                 k, bus.an, bus.seg, bus.load_pending, exp_an(k), SegOff);
      end
    end
  endtask

  initial begin
    bus.en   = 1'b1;
    bus.load = 1'b0;
    set_codes(4'h0, 4'h0, 4'h0, 4'h0);
    test_reset();
    test_idle();
    test_commit();
    test_last_wins();
    test_boundary_load();
    test_enable_gap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
